// File: rtl/ascon_result_deser.sv
// Purpose: times the ASCON core from start to ready, then deserializes its data/tag streams into words.
// Latency: first bit captured START_DELAY+1 cycles after the ready edge; out_valid rises MAX+START_DELAY+1 cycles after it.
// Backpressure: result held stable in HOLD while out_valid=1 and out_ready=0; new start/ready edges are ignored until handshake.
module ascon_result_deser #(
   parameter int Y_WIDTH     = 104,
   parameter int TAG_WIDTH   = 128,
   parameter int START_DELAY = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 ready_i,
   input  logic                 dec_i,
   input  logic                 data_si,
   input  logic                 tag_si,
   input  logic                 clr_i,
   output logic [Y_WIDTH-1:0]   data_o,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic                 dec_o,
   output logic [CNT_WIDTH-1:0] cycles_o,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy_o
);

   localparam int MAX_W = (Y_WIDTH > TAG_WIDTH) ? Y_WIDTH : TAG_WIDTH;
   localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   // The delay register holds START_DELAY-1 at most, so clog2(START_DELAY) bits suffice.
   localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_W - 1);
   localparam logic [DLY_W-1:0] DLY_INIT = (START_DELAY > 0) ? DLY_W'(START_DELAY - 1) : '0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      WAIT  = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } state_t;

   // With no idle delay the first capture happens on the cycle right after the ready edge.
   localparam state_t POST_READY = (START_DELAY == 0) ? SHIFT : WAIT;

   state_t                state_q, state_d;
   logic                  start_q, ready_q;
   logic                  start_rise, ready_rise;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_inc;
   logic [DLY_W-1:0]      dly_q;
   logic [IDX_W-1:0]      idx_q;
   logic [Y_WIDTH-1:0]    data_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [CNT_WIDTH-1:0]  cycles_q;
   logic                  dec_q;
   logic                  valid_q;

   assign start_rise = start_i & ~start_q;
   assign ready_rise = ready_i & ~ready_q;
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   // Previous-cycle copies of the core strobes; keep updating through clr so held levels never refire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         start_q <= start_i;
         ready_q <= ready_i;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; edges outside IDLE/RUN are deliberately not looked at.
   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_rise)      state_d = RUN;
               else if (ready_rise) state_d = POST_READY;
            end
            RUN:   if (ready_rise)           state_d = POST_READY;
            WAIT:  if (dly_q == '0)          state_d = SHIFT;
            SHIFT: if (idx_q == LAST_IDX)    state_d = HOLD;
            HOLD:  if (valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Latency counter, delay countdown, serial capture and result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         dly_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         tag_q    <= '0;
         cycles_q <= '0;
         dec_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else if (clr_i) begin
         cnt_q    <= '0;
         dly_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         tag_q    <= '0;
         cycles_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_rise) begin
                  cnt_q <= '0;
               end else if (ready_rise) begin
                  cycles_q <= '0;
                  dec_q    <= dec_i;
                  dly_q    <= DLY_INIT;
                  idx_q    <= '0;
               end
            end
            RUN: begin
               // The ready edge cycle itself counts, so latency = counter + 1.
               if (ready_rise) begin
                  cycles_q <= cnt_inc;
                  dec_q    <= dec_i;
                  dly_q    <= DLY_INIT;
                  idx_q    <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            WAIT: begin
               if (dly_q != '0) dly_q <= dly_q - DLY_W'(1);
            end
            SHIFT: begin
               for (int i = 0; i < Y_WIDTH; i++)
                  if (IDX_W'(i) == idx_q) data_q[i] <= data_si;
               for (int i = 0; i < TAG_WIDTH; i++)
                  if (IDX_W'(i) == idx_q) tag_q[i] <= tag_si;
               idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
            HOLD: begin
               // One settling cycle with out_valid low, then hold until accepted.
               if (!valid_q)       valid_q <= 1'b1;
               else if (out_ready) valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign data_o    = data_q;
   assign tag_o     = tag_q;
   assign dec_o     = dec_q;
   assign cycles_o  = cycles_q;
   assign out_valid = valid_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_result_deser.sv
// Directed bench for ascon_result_deser: latency, capture, handshake, retrigger, abort and reset.
// A second instance with a 4-bit counter shares the stimulus to show saturation.
// Inputs change and outputs are sampled on the falling edge.
module tb_ascon_result_deser;

   localparam int YW = 104;
   localparam int TW = 128;
   localparam int SD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i, ready_i, dec_i, data_si, tag_si, clr_i, out_ready;
   logic [YW-1:0] data_o;
   logic [TW-1:0] tag_o;
   logic          dec_o, out_valid, busy_o;
   logic [15:0]   cycles_o;

   logic [YW-1:0] s_data_o;
   logic [TW-1:0] s_tag_o;
   logic          s_dec_o, s_out_valid, s_busy_o;
   logic [3:0]    s_cycles_o;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [YW-1:0] CT  = 104'h18490112f8d5867a830748390b;
   localparam logic [YW-1:0] PT  = 104'h6173636f6e2d756e6963617373;
   localparam logic [TW-1:0] TA5 = {16{8'hA5}};
   localparam logic [TW-1:0] TG2 = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [YW-1:0] D3  = 104'hdeadbeef_00112233_44556677_88;
   localparam logic [TW-1:0] TG3 = 128'h3c3c3c3c_0f0f0f0f_f0f0f0f0_c3c3c3c3;

   always #5 clk = ~clk;

   ascon_result_deser #(.Y_WIDTH(YW), .TAG_WIDTH(TW), .START_DELAY(SD), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_i(ready_i), .dec_i(dec_i),
      .data_si(data_si), .tag_si(tag_si), .clr_i(clr_i), .data_o(data_o), .tag_o(tag_o),
      .dec_o(dec_o), .cycles_o(cycles_o), .out_valid(out_valid), .out_ready(out_ready),
      .busy_o(busy_o));

   ascon_result_deser #(.Y_WIDTH(YW), .TAG_WIDTH(TW), .START_DELAY(SD), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_i(ready_i), .dec_i(dec_i),
      .data_si(data_si), .tag_si(tag_si), .clr_i(clr_i), .data_o(s_data_o), .tag_o(s_tag_o),
      .dec_o(s_dec_o), .cycles_o(s_cycles_o), .out_valid(s_out_valid), .out_ready(out_ready),
      .busy_o(s_busy_o));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise ready before a posedge; returns on the falling edge after that posedge (ready edge N).
   task automatic ready_edge();
      ready_i = 1'b1;
      @(negedge clk);
   endtask

   // Feed serial bits so capture k lands on posedge N+SD+1+k; optional clr, start pulse and ready drop.
   task automatic stream(input logic [YW-1:0] d, input logic [TW-1:0] t,
                         input int clr_k, input int start_k, input int rdy_drop_k);
      repeat (SD) @(negedge clk);
      for (int k = 0; k < TW; k++) begin
         if (k == clr_k) begin
            clr_i = 1'b1;
            @(negedge clk);
            clr_i   = 1'b0;
            data_si = 1'b0;
            tag_si  = 1'b0;
            return;
         end
         data_si = (k < YW) ? d[k] : 1'b0;
         tag_si  = t[k];
         start_i = (k == start_k);
         if (k == rdy_drop_k) ready_i = 1'b0;
         @(negedge clk);
      end
      start_i = 1'b0;
      data_si = 1'b0;
      tag_si  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit vld_seen;
      rst_n = 1'b0; start_i = 0; ready_i = 0; dec_i = 0; data_si = 0; tag_si = 0;
      clr_i = 0; out_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_data",   data_o, '0);
      chk("rst_tag",    tag_o, '0);
      chk("rst_cycles", cycles_o, '0);
      chk("rst_dec",    dec_o, '0);
      chk("rst_valid",  out_valid, '0);
      chk("rst_busy",   busy_o, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Encrypt: start held 6 cycles, ready edge 40 cycles after the start edge.
      start_i = 1'b1;
      repeat (6) @(negedge clk);
      start_i = 1'b0;
      chk("enc_busy_run", busy_o, 1'b1);
      repeat (34) @(negedge clk);
      ready_edge();
      chk("enc_cycles", cycles_o, 16'd40);
      chk("sat_cycles", s_cycles_o, 4'd15);
      chk("enc_dec", dec_o, 1'b0);
      stream(CT, TA5, -1, -1, -1);
      chk("enc_valid_early", out_valid, 1'b0);
      @(negedge clk);
      chk("enc_valid", out_valid, 1'b1);
      chk("enc_data", data_o, CT);
      chk("enc_tag", tag_o, TA5);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("enc_valid_drop", out_valid, 1'b0);
      chk("enc_busy_idle", busy_o, 1'b0);
      // ready still high in IDLE: a held level must not start a new capture.
      repeat (3) @(negedge clk);
      chk("enc_ready_level", busy_o, 1'b0);
      ready_i = 1'b0;
      @(negedge clk);

      // Decrypt: 10-cycle latency, start pulse mid-capture, ready dropped mid-capture.
      dec_i   = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      ready_edge();
      dec_i = 1'b0;
      chk("dec_cycles", cycles_o, 16'd10);
      chk("dec_sat_cycles", s_cycles_o, 4'd10);
      stream(PT, TG2, -1, 20, 30);
      @(negedge clk);
      chk("dec_valid", out_valid, 1'b1);
      chk("dec_data", data_o, PT);
      chk("dec_tag", tag_o, TG2);
      chk("dec_dec", dec_o, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("dec_hold_valid", out_valid, 1'b1);
         chk("dec_hold_data", data_o, PT);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("dec_valid_drop", out_valid, 1'b0);
      chk("dec_busy_idle", busy_o, 1'b0);
      chk("dec_data_kept", data_o, PT);
      repeat (2) @(negedge clk);

      // Abort: clr at capture 50, nothing presented, registers cleared.
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      ready_edge();
      chk("abt_cycles", cycles_o, 16'd5);
      stream(CT, TA5, 50, -1, -1);
      chk("abt_busy", busy_o, 1'b0);
      chk("abt_data", data_o, '0);
      chk("abt_tag", tag_o, '0);
      chk("abt_cycles_clr", cycles_o, '0);
      vld_seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (out_valid) vld_seen = 1'b1;
      end
      chk("abt_never_valid", vld_seen, 1'b0);
      ready_i = 1'b0;
      @(negedge clk);

      // Full run after abort.
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      ready_edge();
      stream(D3, TG3, -1, -1, -1);
      @(negedge clk);
      chk("rerun_valid", out_valid, 1'b1);
      chk("rerun_cycles", cycles_o, 16'd7);
      chk("rerun_data", data_o, D3);
      chk("rerun_tag", tag_o, TG3);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      ready_i   = 1'b0;
      @(negedge clk);

      // Async reset while waiting for the first capture.
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      dec_i = 1'b1;
      ready_edge();
      dec_i = 1'b0;
      chk("ar_busy_pre", busy_o, 1'b1);
      chk("ar_cycles_pre", cycles_o, 16'd3);
      #1 rst_n = 1'b0;
      ready_i = 1'b0;
      #1;
      chk("ar_busy", busy_o, 1'b0);
      chk("ar_cycles", cycles_o, '0);
      chk("ar_dec", dec_o, 1'b0);
      chk("ar_data", data_o, '0);
      chk("ar_valid", out_valid, 1'b0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ar_idle", busy_o, 1'b0);
      ready_edge();
      chk("ar_wait_busy", busy_o, 1'b1);
      stream(PT, TA5, -1, -1, -1);
      @(negedge clk);
      chk("nr_valid", out_valid, 1'b1);
      chk("nr_cycles", cycles_o, '0);
      chk("nr_data", data_o, PT);
      chk("nr_tag", tag_o, TA5);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("nr_valid_drop", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
